// File: rtl/ball_collision_unit.sv
// Per-tick collision detector for the pong ball: wall/paddle bounce pulses, miss pulses
// and a saturating rally hit counter, with per-axis lockout and post-miss recovery.
module ball_collision_unit #(
    parameter int unsigned BALL_SIZE  = 8,
    parameter int unsigned PADDLE_W   = 10,
    parameter int unsigned PADDLE_H   = 80,
    parameter int unsigned LPAD_X     = 20,
    parameter int unsigned RPAD_X     = 610,
    parameter int unsigned WALL_TOP   = 10,
    parameter int unsigned WALL_BOT   = 470,
    parameter int unsigned LOCKOUT    = 4,
    parameter int unsigned CENTRE_WIN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [8:0] lpad_y,
    input  logic [8:0] rpad_y,
    output logic       v_col,
    output logic       h_col,
    output logic       miss_left,
    output logic       miss_right,
    output logic [7:0] hit_count
);

    localparam logic [0:0] PLAY    = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

    localparam logic [10:0] LX_LO = 11'(LPAD_X);
    localparam logic [10:0] LX_HI = 11'(LPAD_X + PADDLE_W);
    localparam logic [10:0] RX_LO = 11'(RPAD_X);
    localparam logic [10:0] RX_HI = 11'(RPAD_X + PADDLE_W);
    localparam logic [10:0] CX_LO = 11'(320 - CENTRE_WIN);
    localparam logic [10:0] CX_HI = 11'(320 + CENTRE_WIN);
    localparam logic [9:0]  WT    = 10'(WALL_TOP);
    localparam logic [9:0]  WB    = 10'(WALL_BOT);
    localparam logic [3:0]  LOCK_LOAD = 4'(LOCKOUT);

    // Widened by one bit so edge sums never wrap.
    logic [10:0] bx, bx_r;
    logic [9:0]  by, by_b, lp_top, lp_bot, rp_top, rp_bot;

    assign bx     = {1'b0, ball_x};
    assign bx_r   = bx + 11'(BALL_SIZE);
    assign by     = {1'b0, ball_y};
    assign by_b   = by + 10'(BALL_SIZE);
    assign lp_top = {1'b0, lpad_y};
    assign lp_bot = lp_top + 10'(PADDLE_H);
    assign rp_top = {1'b0, rpad_y};
    assign rp_bot = rp_top + 10'(PADDLE_H);

    logic wall_hit, l_ovl, r_ovl, lhit, rhit, lmiss, rmiss, in_centre;

    assign wall_hit  = (by <= WT) | (by_b >= WB);
    assign l_ovl     = (by_b > lp_top) & (by < lp_bot);
    assign r_ovl     = (by_b > rp_top) & (by < rp_bot);
    assign lhit      = (bx >= LX_LO) & (bx <= LX_HI) & l_ovl;
    assign rhit      = (bx_r >= RX_LO) & (bx_r <= RX_HI) & r_ovl;
    assign lmiss     = (bx < LX_LO) & ~lhit;
    assign rmiss     = (bx_r > RX_HI) & ~rhit;
    assign in_centre = (bx >= CX_LO) & (bx <= CX_HI);

    logic [0:0] state_q, state_d;
    logic [3:0] v_lock_q, v_lock_d, h_lock_q, h_lock_d;
    logic [7:0] cnt_q, cnt_d;
    logic       v_col_q, v_col_d, h_col_q, h_col_d;
    logic       ml_q, ml_d, mr_q, mr_d;

    always_comb begin
        state_d  = state_q;
        v_lock_d = v_lock_q;
        h_lock_d = h_lock_q;
        cnt_d    = cnt_q;
        v_col_d  = 1'b0;
        h_col_d  = 1'b0;
        ml_d     = 1'b0;
        mr_d     = 1'b0;
        if (tick) begin
            if (v_lock_q != 4'd0) v_lock_d = v_lock_q - 4'd1;
            if (h_lock_q != 4'd0) h_lock_d = h_lock_q - 4'd1;
            if (state_q == PLAY) begin
                if (wall_hit && (v_lock_q == 4'd0)) begin
                    v_col_d  = 1'b1;
                    v_lock_d = LOCK_LOAD;
                end
                if ((lhit | rhit) && (h_lock_q == 4'd0)) begin
                    h_col_d  = 1'b1;
                    h_lock_d = LOCK_LOAD;
                    if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
                end
                if (lmiss) begin
                    ml_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = RECOVER;
                end else if (rmiss) begin
                    mr_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = RECOVER;
                end
            end else if (in_centre) begin
                state_d  = PLAY;
                v_lock_d = 4'd0;
                h_lock_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAY;
            v_lock_q <= 4'd0;
            h_lock_q <= 4'd0;
            cnt_q    <= 8'd0;
            v_col_q  <= 1'b0;
            h_col_q  <= 1'b0;
            ml_q     <= 1'b0;
            mr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_lock_q <= v_lock_d;
            h_lock_q <= h_lock_d;
            cnt_q    <= cnt_d;
            v_col_q  <= v_col_d;
            h_col_q  <= h_col_d;
            ml_q     <= ml_d;
            mr_q     <= mr_d;
        end
    end

    assign v_col      = v_col_q;
    assign h_col      = h_col_q;
    assign miss_left  = ml_q;
    assign miss_right = mr_q;
    assign hit_count  = cnt_q;

endmodule

// File: tb/tb_ball_collision_unit.sv
// Scoreboard bench for ball_collision_unit: a behavioural model queues expected results per tick
// and a negedge monitor compares them the cycle after each tick.
module tb_ball_collision_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic [8:0] ball_y = 9'd240;
    logic [8:0] lpad_y = 9'd200;
    logic [8:0] rpad_y = 9'd200;
    logic       v_col, h_col, miss_left, miss_right;
    logic [7:0] hit_count;

    ball_collision_unit dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .lpad_y     (lpad_y),
        .rpad_y     (rpad_y),
        .v_col      (v_col),
        .h_col      (h_col),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit h;
        bit ml;
        bit mr;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    bit m_rec = 0;
    int m_vlock = 0;
    int m_hlock = 0;
    int m_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_tick(input int x, input int y, input int lp, input int rp,
                              output exp_t e);
        int  bx8, by8, vl, hl;
        bit  wall, lov, rov, lh, rh, lm, rm;
        bx8  = x + 8;
        by8  = y + 8;
        wall = (y <= 10) || (by8 >= 470);
        lov  = (by8 > lp) && (y < lp + 80);
        rov  = (by8 > rp) && (y < rp + 80);
        lh   = (x >= 20) && (x <= 30) && lov;
        rh   = (bx8 >= 610) && (bx8 <= 620) && rov;
        lm   = (x < 20) && !lh;
        rm   = (bx8 > 620) && !rh;
        e    = '{v: 0, h: 0, ml: 0, mr: 0, cnt: 0};
        vl   = m_vlock;
        hl   = m_hlock;
        if (m_vlock > 0) m_vlock--;
        if (m_hlock > 0) m_hlock--;
        if (!m_rec) begin
            if (wall && vl == 0) begin
                e.v = 1;
                m_vlock = 4;
            end
            if ((lh || rh) && hl == 0) begin
                e.h = 1;
                m_hlock = 4;
                if (m_cnt < 255) m_cnt++;
            end
            if (lm) begin
                e.ml = 1;
                m_cnt = 0;
                m_rec = 1;
            end else if (rm) begin
                e.mr = 1;
                m_cnt = 0;
                m_rec = 1;
            end
        end else if (x >= 304 && x <= 336) begin
            m_rec = 0;
            m_vlock = 0;
            m_hlock = 0;
        end
        e.cnt = m_cnt;
    endtask

    task automatic do_tick(input int x, input int y, input int lp, input int rp);
        exp_t e;
        @(negedge clk);
        ball_x = 10'(x);
        ball_y = 9'(y);
        lpad_y = 9'(lp);
        rpad_y = 9'(rp);
        tick   = 1'b1;
        model_tick(x, y, lp, rp, e);
        sb.push_back(e);
        @(negedge clk);
        tick = 1'b0;
    endtask

    // A tick was sampled at the last posedge; its result is due now.
    logic pending;
    always @(posedge clk or posedge reset) begin
        if (reset) pending <= 1'b0;
        else       pending <= tick;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (pending) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("v_col", 32'(v_col), 32'(e.v));
                    check_val("h_col", 32'(h_col), 32'(e.h));
                    check_val("miss_left", 32'(miss_left), 32'(e.ml));
                    check_val("miss_right", 32'(miss_right), 32'(e.mr));
                    check_val("hit_count", 32'(hit_count), 32'(e.cnt));
                end
            end else begin
                check_val("idle_pulses", 32'({v_col, h_col, miss_left, miss_right}), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_pulses", 32'({v_col, h_col, miss_left, miss_right}), 32'd0);
        check_val("rst_count", 32'(hit_count), 32'd0);
        reset = 1'b0;

        // Wall contact and lockout: fires, 4 blind ticks, fires again
        for (int i = 0; i < 6; i++) do_tick(320, 10, 200, 200);
        do_tick(320, 240, 200, 200);
        do_tick(320, 462, 200, 200);

        // Left paddle hit, then moved paddle within lockout and after
        for (int i = 0; i < 5; i++) do_tick(320, 240, 200, 200);
        do_tick(30, 230, 200, 200);
        for (int i = 0; i < 6; i++) do_tick(30, 230, 300, 200);
        do_tick(20, 150, 100, 200);

        // Left miss, recovery blindness, re-centre
        do_tick(15, 400, 0, 200);
        do_tick(15, 400, 0, 200);
        do_tick(620, 20, 0, 200);
        do_tick(303, 240, 0, 200);
        do_tick(336, 240, 0, 200);
        do_tick(320, 10, 0, 200);

        // Corner: wall and right paddle together, no miss
        for (int i = 0; i < 5; i++) do_tick(320, 240, 0, 200);
        do_tick(612, 466, 0, 420);
        // Right miss
        for (int i = 0; i < 5; i++) do_tick(320, 240, 0, 420);
        do_tick(613, 240, 0, 420);
        do_tick(304, 240, 0, 420);

        // Gating: wall condition present but no tick
        @(negedge clk);
        ball_y = 9'd10;
        repeat (20) @(negedge clk);

        // Saturation via 300 spaced right-paddle hits
        for (int i = 0; i < 1500; i++) do_tick(605, 220, 0, 200);
        @(negedge clk);
        check_val("sat_count", 32'(hit_count), 32'd255);

        // Reset in the middle of a tick cycle
        @(negedge clk);
        ball_x = 10'd320;
        ball_y = 9'd10;
        tick   = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_val("midrst_pulses", 32'({v_col, h_col, miss_left, miss_right}), 32'd0);
        check_val("midrst_count", 32'(hit_count), 32'd0);
        @(negedge clk);
        tick  = 1'b0;
        sb.delete();
        m_rec = 0;
        m_vlock = 0;
        m_hlock = 0;
        m_cnt = 0;
        reset = 1'b0;

        // After reset: PLAY, no stale lockout
        do_tick(605, 220, 0, 200);
        do_tick(320, 10, 0, 200);

        repeat (3) @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
